// File: rtl/led_matrix_scan_pkg.sv
// Shared helpers for the LED matrix scan driver: width math, polarity masks,
// and frame-period arithmetic.
package led_mat_pkg;

  function automatic int clog2(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

  // All-ones when the output is active-low; slice to the port width at use.
  function automatic logic [63:0] pol_mask(input bit active_low);
    return active_low ? {64{1'b1}} : 64'd0;
  endfunction

  function automatic int frame_cycles(input int rows, input int k, input int pwm_bits);
    return rows * (1 << pwm_bits) * k;
  endfunction

endpackage

// File: rtl/led_matrix_scan_if.sv
// Host-side write/swap/brightness bus and matrix pin outputs of the scan driver.
interface led_matrix_scan_if #(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int PWM_BITS = 2
);
  localparam int AW = led_mat_pkg::clog2(ROWS);

  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [COLS-1:0]     wr_data;
  logic                swap_req;
  logic                swap_ack;
  logic [PWM_BITS-1:0] brightness;
  logic [ROWS-1:0]     row;
  logic [COLS-1:0]     col;
  logic                frame_start;

  modport master (
    output wr_en, wr_addr, wr_data, swap_req, brightness,
    input  swap_ack, row, col, frame_start
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, swap_req, brightness,
    output swap_ack, row, col, frame_start
  );

endinterface

// File: rtl/led_matrix_scan_timer.sv
// Scan timebase: prescaler to tick, PWM phase per tick, row index per full phase cycle.
module led_scan_timer
  import led_mat_pkg::*;
#(
  parameter int  ROWS     = 8,
  parameter int  K        = 10,
  parameter int  PWM_BITS = 2,
  localparam int RW       = clog2(ROWS)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                tick,
  output logic [PWM_BITS-1:0] ph,
  output logic [RW-1:0]       r,
  output logic                row_start,
  output logic                frame_wrap
);

  localparam int PW = (K > 1) ? clog2(K) : 1;
  localparam logic [PW-1:0]       PCNT_MAX = PW'(K - 1);
  localparam logic [PWM_BITS-1:0] PH_MAX   = '1;
  localparam logic [RW-1:0]       R_MAX    = RW'(ROWS - 1);

  logic [PW-1:0] pcnt;

  assign tick      = (pcnt == PCNT_MAX);
  assign row_start = (pcnt == '0) && (ph == '0);
  // Last dwell of the last row: the next tick closes the frame.
  assign frame_wrap = (ph == PH_MAX) && (r == R_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= '0;
      ph   <= '0;
      r    <= '0;
    end else begin
      pcnt <= tick ? '0 : pcnt + 1'b1;
      if (tick) begin
        ph <= ph + 1'b1;
        if (ph == PH_MAX) r <= (r == R_MAX) ? '0 : r + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_matrix_scan.sv
// Row-scan LED matrix driver: double-buffered frame store, frame-boundary bank swap,
// per-row PWM brightness and configurable output polarity.
module led_matrix_scan
  import led_mat_pkg::*;
#(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int K        = 10,
  parameter int PWM_BITS = 2,
  parameter bit ROW_AL   = 1'b0,
  parameter bit COL_AL   = 1'b0
) (
  input logic              clk,
  input logic              rst,
  led_matrix_scan_if.slave bus
);

  localparam int RW = clog2(ROWS);
  localparam logic [63:0]     ROW_M64  = pol_mask(ROW_AL);
  localparam logic [63:0]     COL_M64  = pol_mask(COL_AL);
  localparam logic [ROWS-1:0] ROW_MASK = ROW_M64[ROWS-1:0];
  localparam logic [COLS-1:0] COL_MASK = COL_M64[COLS-1:0];
  localparam logic [RW:0]     ROWS_L   = (RW + 1)'(ROWS);

  logic                tick;
  logic [PWM_BITS-1:0] ph;
  logic [RW-1:0]       r;
  logic                row_start;
  logic                frame_wrap;

  led_scan_timer #(.ROWS(ROWS), .K(K), .PWM_BITS(PWM_BITS)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .ph         (ph),
    .r          (r),
    .row_start  (row_start),
    .frame_wrap (frame_wrap)
  );

  logic [COLS-1:0]     bank [2][ROWS];
  logic                sel;
  logic                pending;
  logic                swap_p0;
  logic [PWM_BITS-1:0] bl;
  logic                frame_end;
  logic                do_swap;
  logic                wr_ok;
  logic                en;
  logic [ROWS-1:0]     onehot;
  logic [ROWS-1:0]     row_p1;
  logic [COLS-1:0]     col_p1;
  logic                fs_p1;
  logic                ack_p1;

  assign frame_end = tick && frame_wrap;
  // A request arriving in the boundary cycle itself is serviced immediately.
  assign do_swap   = frame_end && (pending || bus.swap_req);
  assign wr_ok     = ({1'b0, bus.wr_addr} < ROWS_L);
  assign en        = (ph <= bl);
  assign onehot    = {{(ROWS-1){1'b0}}, 1'b1} << r;

  // p0 -> p1: registered pin drive; swap_p0 delays the ack to line up with frame_start.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel     <= 1'b0;
      pending <= 1'b0;
      swap_p0 <= 1'b0;
      bl      <= '0;
      row_p1  <= ROW_MASK;
      col_p1  <= COL_MASK;
      fs_p1   <= 1'b0;
      ack_p1  <= 1'b0;
      for (int i = 0; i < ROWS; i++) begin
        bank[0][i] <= '0;
        bank[1][i] <= '0;
      end
    end else begin
      if (row_start) bl <= bus.brightness;
      row_p1  <= (en ? onehot : '0) ^ ROW_MASK;
      col_p1  <= (en ? bank[sel][r] : '0) ^ COL_MASK;
      fs_p1   <= row_start && (r == '0);
      swap_p0 <= do_swap;
      ack_p1  <= swap_p0;
      if (do_swap) begin
        sel     <= ~sel;
        pending <= 1'b0;
      end else if (bus.swap_req) begin
        pending <= 1'b1;
      end
      // Uses the pre-toggle select, so a swap-cycle write lands in the new front bank.
      if (bus.wr_en && wr_ok) bank[~sel][bus.wr_addr] <= bus.wr_data;
    end
  end

  assign bus.row         = row_p1;
  assign bus.col         = col_p1;
  assign bus.frame_start = fs_p1;
  assign bus.swap_ack    = ack_p1;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Scoreboard bench for led_matrix_scan: two instances (8-row active-high, 6-row active-low)
// checked every cycle against a position-based reference model.
module tb_led_matrix_scan;

  localparam int K = 10;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       swap_req;
  logic [1:0] brightness;

  led_matrix_scan_if #(.ROWS(8), .COLS(8), .PWM_BITS(2)) bus0 ();
  led_matrix_scan_if #(.ROWS(6), .COLS(8), .PWM_BITS(2)) bus1 ();

  assign bus0.wr_en = wr_en;       assign bus1.wr_en = wr_en;
  assign bus0.wr_addr = wr_addr;   assign bus1.wr_addr = wr_addr;
  assign bus0.wr_data = wr_data;   assign bus1.wr_data = wr_data;
  assign bus0.swap_req = swap_req; assign bus1.swap_req = swap_req;
  assign bus0.brightness = brightness;
  assign bus1.brightness = brightness;

  led_matrix_scan #(.ROWS(8), .COLS(8), .K(K), .PWM_BITS(2), .ROW_AL(1'b0), .COL_AL(1'b0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  led_matrix_scan #(.ROWS(6), .COLS(8), .K(K), .PWM_BITS(2), .ROW_AL(1'b1), .COL_AL(1'b1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] row;
    logic [7:0] col;
    logic       fs;
    logic       ack;
  } obs_t;

  obs_t q0[$];
  obs_t q1[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference state: cycles since reset, both banks, front select, pending, latched level.
  int         m_rows[2] = '{8, 6};
  bit         m_al[2]   = '{1'b0, 1'b1};
  int         n[2];
  logic [7:0] mbank[2][2][8];
  int         msel[2];
  bit         mpend[2];
  bit         mswapped[2];
  int         mbl[2];

  task automatic model_step(input int i, output obs_t e);
    int period, pos, r, ph, pc;
    bit en;
    logic [7:0] rmask, cmask;
    rmask = m_al[i] ? 8'((1 << m_rows[i]) - 1) : 8'd0;
    cmask = m_al[i] ? 8'hFF : 8'h00;
    if (rst) begin
      n[i] = 0; msel[i] = 0; mpend[i] = 1'b0; mswapped[i] = 1'b0; mbl[i] = 0;
      for (int b = 0; b < 2; b++)
        for (int a = 0; a < 8; a++) mbank[i][b][a] = 8'h00;
      e.row = rmask; e.col = cmask; e.fs = 1'b0; e.ack = 1'b0;
      return;
    end
    period = m_rows[i] * D * K;
    pos    = n[i] % period;
    r      = pos / (D * K);
    ph     = (pos / K) % D;
    pc     = pos % K;
    if (ph == 0 && pc == 0) mbl[i] = int'(brightness);
    en    = (ph <= mbl[i]);
    e.row = (en ? 8'(1 << r) : 8'd0) ^ rmask;
    e.col = (en ? mbank[i][msel[i]][r] : 8'd0) ^ cmask;
    e.fs  = (pos == 0);
    e.ack = mswapped[i];
    if (wr_en && int'(wr_addr) < m_rows[i]) mbank[i][1 - msel[i]][wr_addr] = wr_data;
    if (swap_req) mpend[i] = 1'b1;
    mswapped[i] = (pos == period - 1) && mpend[i];
    if (mswapped[i]) begin
      msel[i]  = 1 - msel[i];
      mpend[i] = 1'b0;
    end
    n[i]++;
  endtask

  task automatic cyc();
    obs_t e0, e1;
    @(posedge clk);
    model_step(0, e0);
    model_step(1, e1);
    q0.push_back(e0);
    q1.push_back(e1);
    #1;
  endtask

  task automatic idle(input int nc);
    for (int c = 0; c < nc; c++) cyc();
  endtask

  task automatic write_row(input logic [2:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1;
    cyc();
    swap_req = 1'b0;
  endtask

  task automatic check(input int id, input obs_t a, input obs_t e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL dut%0d @%0t: got row=%h col=%h fs=%b ack=%b, want row=%h col=%h fs=%b ack=%b",
               id, $time, a.row, a.col, a.fs, a.ack, e.row, e.col, e.fs, e.ack);
    end
  endtask

  always @(negedge clk) begin
    obs_t a, e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      a = {bus0.row, bus0.col, bus0.frame_start, bus0.swap_ack};
      check(0, a, e);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      a = {2'b00, bus1.row, bus1.col, bus1.frame_start, bus1.swap_ack};
      check(1, a, e);
    end
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; swap_req = 1'b0; brightness = 2'd3;
    idle(3);
    rst = 1'b0;
    idle(660);

    // Single row pattern, swap requested mid-frame.
    write_row(3'd3, 8'hA5);
    idle(100);
    pulse_swap();
    idle(700);

    // Dim then full brightness, then a level changed part-way through a row.
    brightness = 2'd0;
    idle(700);
    brightness = 2'd1;
    idle(95);
    brightness = 2'd3;
    idle(330);

    // Back-bank write without swap stays invisible for several frames.
    write_row(3'd3, 8'h3C);
    idle(980);

    // Rows 6/7 exist only on the 8-row instance; the 6-row one must drop them.
    write_row(3'd6, 8'hFF);
    write_row(3'd7, 8'h81);
    write_row(3'd0, 8'h11);
    pulse_swap();
    idle(700);

    // Reset in the middle of row 5 with a swap pending.
    for (int j = 0; j < 400 && (n[0] % 320) != 215; j++) cyc();
    write_row(3'd2, 8'h5A);
    pulse_swap();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    idle(700);

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      wr_en      = ($urandom_range(0, 3) == 0);
      wr_addr    = 3'($urandom_range(0, 7));
      wr_data    = 8'($urandom);
      swap_req   = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 49) == 0) brightness = 2'($urandom_range(0, 3));
      rst        = ($urandom_range(0, 1499) == 0);
      cyc();
    end
    rst = 1'b0; wr_en = 1'b0; swap_req = 1'b0;
    idle(2);
    @(negedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
